// File: rtl/poly_mul_pkg.sv
// Shared definitions for the polynomial-multiplier sequencer: state encoding,
// operation-table entry layout and the default operation programme.
package poly_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_e;

  // Widest fields any build may use; narrower builds take the low bits.
  localparam int MAX_CONF_W = 8;
  localparam int MAX_SEL_W  = 4;

  typedef struct packed {
    logic [MAX_CONF_W-1:0] conf;
    logic [MAX_SEL_W-1:0]  sel;
    logic                  last;
  } def_entry_t;

  localparam int OP_NTT  = 1;
  localparam int OP_PWM  = 4;
  localparam int OP_INTT = 3;
  localparam int OP_FIN  = 5;

  // Packed entry layout is {conf, sel, last}, last in bit 0.
  function automatic int entry_width(input int conf_w, input int sel_w);
    return conf_w + sel_w + 1;
  endfunction

  function automatic def_entry_t default_entry(input int idx);
    def_entry_t e;
    e = '0;
    case (idx)
      0: begin
        e.conf = 8'(OP_NTT);
        e.sel  = 4'd0;
        e.last = 1'b0;
      end
      1: begin
        e.conf = 8'(OP_PWM);
        e.sel  = 4'd1;
        e.last = 1'b0;
      end
      2: begin
        e.conf = 8'(OP_INTT);
        e.sel  = 4'd2;
        e.last = 1'b0;
      end
      3: begin
        e.conf = 8'(OP_FIN);
        e.sel  = 4'd2;
        e.last = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/poly_mul_sequencer_table.sv
// seq_op_table: N_OPS-deep operation table with synchronous write, reset to the
// default programme, and two combinational read ports (current entry, entry to load).
module seq_op_table
  import poly_mul_pkg::*;
#(
  parameter int CONF_W = 3,
  parameter int SEL_W  = 2,
  parameter int N_OPS  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [CONF_W-1:0] wconf,
  input  logic [SEL_W-1:0]  wsel,
  input  logic              wlast,
  input  logic [IDX_W-1:0]  raddr,
  output logic [SEL_W-1:0]  rsel,
  output logic              rlast,
  input  logic [IDX_W-1:0]  laddr,
  output logic [CONF_W-1:0] lconf
);

  localparam int ENTRY_W = entry_width(CONF_W, SEL_W);

  logic [ENTRY_W-1:0] mem_r [N_OPS];

  function automatic logic [ENTRY_W-1:0] reset_entry(input int idx);
    def_entry_t d;
    d = default_entry(idx);
    return {d.conf[CONF_W-1:0], d.sel[SEL_W-1:0], d.last};
  endfunction

  // Table storage: default programme on reset, host writes otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OPS; i++) begin
        mem_r[i] <= reset_entry(i);
      end
    end else if (we) begin
      mem_r[waddr] <= {wconf, wsel, wlast};
    end
  end

  assign rlast = mem_r[raddr][0];
  assign rsel  = mem_r[raddr][SEL_W:1];
  assign lconf = mem_r[laddr][ENTRY_W-1:SEL_W+1];

endmodule

// File: rtl/poly_mul_sequencer.sv
// poly_mul_sequencer: issues table operations on conf, waits for a done_flag rising
// edge, then idles GAP_CYCLES before the next. Watchdog built when SEQ_TIMEOUT_EN is defined.
module poly_mul_sequencer
#(
  parameter int CONF_W     = 3,
  parameter int DONE_W     = 3,
  parameter int N_OPS      = 4,
  parameter int IDX_W      = 2,
  parameter int SEL_W      = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [CONF_W-1:0] prog_conf,
  input  logic [SEL_W-1:0]  prog_sel,
  input  logic              prog_last,
  input  logic [DONE_W-1:0] done_flag,
  output logic [CONF_W-1:0] conf,
  output logic [IDX_W-1:0]  op_idx,
  output logic              busy,
  output logic              seq_done,
  output logic              error
);

  import poly_mul_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);
  localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  seq_state_e        state_r, state_nxt;
  logic [CONF_W-1:0] conf_r, conf_nxt;
  logic [IDX_W-1:0]  op_idx_r, op_idx_nxt;
  logic              busy_r, busy_nxt;
  logic              seq_done_r, seq_done_nxt;
  logic [7:0]        gap_cnt_r, gap_cnt_nxt;
  logic [DONE_W-1:0] done_q_r;
  logic              tbl_we_s;
  logic [SEL_W-1:0]  cur_sel_s;
  logic              cur_last_s;
  logic [IDX_W-1:0]  ld_addr_s;
  logic [CONF_W-1:0] ld_conf_s;
  logic              event_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_r, wait_nxt;
  logic              error_r, error_nxt;
`endif

  seq_op_table #(
    .CONF_W (CONF_W),
    .SEL_W  (SEL_W),
    .N_OPS  (N_OPS),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we_s),
    .waddr (prog_addr),
    .wconf (prog_conf),
    .wsel  (prog_sel),
    .wlast (prog_last),
    .raddr (op_idx_r),
    .rsel  (cur_sel_s),
    .rlast (cur_last_s),
    .laddr (ld_addr_s),
    .lconf (ld_conf_s)
  );

  // From IDLE the entry to load is entry 0; otherwise the one after the current.
  assign ld_addr_s = (state_r == ST_IDLE) ? {IDX_W{1'b0}} : op_idx_r + IDX_W'(1);

  // Completion event: selected done bit rose since the previous cycle.
  always_comb begin
    event_s = 1'b0;
    for (int i = 0; i < DONE_W; i++) begin
      event_s = (cur_sel_s == SEL_W'(i)) ? (done_flag[i] & ~done_q_r[i]) : event_s;
    end
  end

  // Next-state and next-output logic; abort overrides every state.
  always_comb begin
    state_nxt    = state_r;
    conf_nxt     = conf_r;
    op_idx_nxt   = op_idx_r;
    busy_nxt     = busy_r;
    seq_done_nxt = 1'b0;
    gap_cnt_nxt  = gap_cnt_r;
    tbl_we_s     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wait_nxt     = wait_r;
    error_nxt    = error_r;
`endif
    if (abort) begin
      state_nxt   = ST_IDLE;
      conf_nxt    = {CONF_W{1'b0}};
      op_idx_nxt  = {IDX_W{1'b0}};
      busy_nxt    = 1'b0;
      gap_cnt_nxt = 8'd0;
`ifdef SEQ_TIMEOUT_EN
      wait_nxt    = {WAIT_W{1'b0}};
      error_nxt   = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (prog_we) begin
            tbl_we_s = 1'b1;
          end else if (start) begin
            state_nxt  = ST_RUN;
            conf_nxt   = ld_conf_s;
            op_idx_nxt = {IDX_W{1'b0}};
            busy_nxt   = 1'b1;
`ifdef SEQ_TIMEOUT_EN
            wait_nxt   = {WAIT_W{1'b0}};
`endif
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (event_s) begin
            if (cur_last_s || (op_idx_r == LAST_IDX)) begin
              state_nxt    = ST_IDLE;
              conf_nxt     = {CONF_W{1'b0}};
              busy_nxt     = 1'b0;
              seq_done_nxt = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_nxt   = ST_GAP;
              conf_nxt    = {CONF_W{1'b0}};
              gap_cnt_nxt = GAP_LOAD;
            end else begin
              conf_nxt   = ld_conf_s;
              op_idx_nxt = op_idx_r + IDX_W'(1);
`ifdef SEQ_TIMEOUT_EN
              wait_nxt   = {WAIT_W{1'b0}};
`endif
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wait_r == WAIT_LAST) begin
            state_nxt = ST_ERR;
            conf_nxt  = {CONF_W{1'b0}};
            busy_nxt  = 1'b0;
            error_nxt = 1'b1;
          end else begin
            wait_nxt = wait_r + WAIT_W'(1);
          end
`else
          else begin
            state_nxt = ST_RUN;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt_r == 8'd0) begin
            state_nxt  = ST_RUN;
            conf_nxt   = ld_conf_s;
            op_idx_nxt = op_idx_r + IDX_W'(1);
`ifdef SEQ_TIMEOUT_EN
            wait_nxt   = {WAIT_W{1'b0}};
`endif
          end else begin
            gap_cnt_nxt = gap_cnt_r - 8'd1;
          end
        end
        ST_ERR: begin
          state_nxt = ST_ERR;
        end
        default: begin
          state_nxt = ST_IDLE;
          conf_nxt  = {CONF_W{1'b0}};
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      conf_r     <= {CONF_W{1'b0}};
      op_idx_r   <= {IDX_W{1'b0}};
      busy_r     <= 1'b0;
      seq_done_r <= 1'b0;
      gap_cnt_r  <= 8'd0;
    end else begin
      state_r    <= state_nxt;
      conf_r     <= conf_nxt;
      op_idx_r   <= op_idx_nxt;
      busy_r     <= busy_nxt;
      seq_done_r <= seq_done_nxt;
      gap_cnt_r  <= gap_cnt_nxt;
    end
  end

  // Previous done_flag sample, refreshed every cycle so stale-high bits never count.
  always_ff @(posedge clk) begin
    done_q_r <= done_flag;
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r  <= {WAIT_W{1'b0}};
      error_r <= 1'b0;
    end else begin
      wait_r  <= wait_nxt;
      error_r <= error_nxt;
    end
  end

  assign error = error_r;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign error          = 1'b0;
`endif

  assign conf     = conf_r;
  assign op_idx   = op_idx_r;
  assign busy     = busy_r;
  assign seq_done = seq_done_r;

endmodule

// File: doc/poly_mul_sequencer.md
# poly_mul_sequencer

Handshake-driven operation sequencer for the polynomial-multiplier top. It replaces fixed-delay `conf` stepping with a programmable table of up to `N_OPS` operations (NTT, point-wise multiply, INTT, …). Each operation is issued on `conf`, the sequencer waits for its completion bit on `done_flag`, then inserts a configurable idle gap before the next operation. It sits between the host/bench control and `top_poly_mul`.

## Interface
- `CONF_W`, 3, width of `conf` code
- `DONE_W`, 3, width of `done_flag` from the multiplier
- `N_OPS`, 4, table depth (2..16)
- `IDX_W`, 2, index width = clog2(`N_OPS`)
- `SEL_W`, 2, done-bit selector width = clog2(`DONE_W`)
- `GAP_CYCLES`, 2, idle cycles with `conf`=0 between operations (0..255)
- `TIMEOUT`, 16384, max WAIT cycles per operation (watchdog build only)
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: reset; **synchronous, active-high**
- `start` in 1: begin the sequence at entry 0 (honoured in IDLE only)
- `abort` in 1: return to IDLE from any state
- `prog_we` in 1: table write strobe
- `prog_addr` in `IDX_W`: table entry
- `prog_conf` in `CONF_W`: operation code
- `prog_sel` in `SEL_W`: `done_flag` bit that marks completion
- `prog_last` in 1: entry ends the sequence
- `done_flag` in `DONE_W`: completion flags from the multiplier
- `conf` out `CONF_W`: registered operation code to the multiplier
- `op_idx` out `IDX_W`: current entry
- `busy` out 1: sequence in progress
- `seq_done` out 1: one-cycle pulse when the last entry completes
- `error` out 1: sticky timeout flag

## Operation
- States: IDLE, RUN (`conf` = entry code), GAP, ERR.
- Table entry = {conf, sel, last}.
- Reset loads the default programme: {1,0,0}, {4,1,0}, {3,2,0}, {5,2,1}.
- `prog_we` writes take effect in IDLE only; writes in other states are ignored.
- `start` in the same cycle as `prog_we` is ignored; the write is performed.
- IDLE:
  - `start` moves to RUN with `op_idx`=0 and `conf` = table[0].conf.
  - `start` in any other state is ignored.
- Completion event:
  - Defined as the rising edge of `done_flag[sel]` against a register of `done_flag` updated every cycle.
  - A bit already high at issue does not count.
- On event in RUN:
  - If `last`=1 or `op_idx`=N_OPS-1: `conf`=0, `seq_done` pulses, go to IDLE.
  - Otherwise, with `GAP_CYCLES`>0: `conf`=0, go to GAP.
  - Otherwise, with `GAP_CYCLES`=0: go straight to the next entry.
- GAP:
  - Counts `GAP_CYCLES` cycles.
  - Then increments `op_idx`, loads the next conf, and returns to RUN.
- `abort`:
  - Has priority over everything except `rst`.
  - Next cycle: IDLE, `conf`=0, `op_idx`=0.
  - Clears `error`.
- `busy`=1 in RUN and GAP only.

## Timing
- Reset values: `conf`=0, `op_idx`=0, `busy`=0, `seq_done`=0, `error`=0; the table is reloaded with the default programme.
- `rst` mid-sequence: all of the above on the next edge.
- `start` sampled at edge T: `conf` and `busy` valid from T+1.
- Event sampled at edge E:
  - `conf`=0 from E+1.
  - Next `conf` from E+1+`GAP_CYCLES`.
- Last-entry event at E: `seq_done`=1 for cycle E+1 only; `busy`=0 from E+1.
- Minimum time from issue to the earliest accepted event: 1 cycle.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A WAIT counter clears on each issue and counts every RUN cycle.
  - Reaching `TIMEOUT` without an event: `conf`=0, `busy`=0, `error`=1, state ERR.
  - ERR exits only on `abort` or `rst`; `start` is ignored in ERR.
- `SEQ_TIMEOUT_EN` undefined:
  - No counter; RUN waits indefinitely.
  - `error` is tied to 0 and ERR is unreachable.

## Structure
- Shared package `poly_mul_pkg` holds:
  - State encoding.
  - Entry struct/width constants.
  - Default programme constants (`OP_NTT`=1, `OP_PWM`=4, `OP_INTT`=3, `OP_FIN`=5).
- One sub-module, `seq_op_table`: `N_OPS`-deep register file with synchronous write, reset-to-default, and combinational read.
- FSM, gap counter and watchdog live in the top.

## Test plan
- Default programme, `done_flag` rising-edge bits 0/1/2/2 pulsed 10 cycles after each issue -> `conf` sequence 1,0,0,4,0,0,3,0,0,5,0; `seq_done` pulse one cycle after the fourth event.
- `done_flag[0]` held high before `start` -> entry 0 does not complete until the bit falls and rises again.
- Program entry 1 with `last`=1, `GAP_CYCLES`=0 -> `conf` goes 1 then directly 4; sequence ends after 2 operations.
- `abort` asserted during GAP of entry 1 -> next cycle `conf`=0, `op_idx`=0, `busy`=0; a later `start` restarts at entry 0.
- `SEQ_TIMEOUT_EN`, `TIMEOUT`=32, no event -> `error`=1 and `conf`=0 at issue+32; `start` ignored; `abort` clears `error`.
- `prog_we` while `busy` -> table unchanged; the following run uses the old codes.
